// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage
//
// Registered RV32I(+M) decode stage that sits between fetch and the
// register-read/execute stage. The incoming instruction is decoded
// combinationally into the pipeline control bundle. The bundle is captured in
// an output register when an instruction is loaded (in_valid & in_ready), so
// the stage has one cycle of latency. A valid/ready pair sits on each side.
//
// When a MUL/DIV bundle is handed downstream, the stage holds off new
// instructions until the execute unit has had time to finish. A synchronous
// flush drops the held bundle and cancels that interlock.
//
// Parameters
//   ENABLE_M    1 = decode the MUL/DIV group. 0 = funct7 0000001 R-types
//               are reported as illegal.
//   MUL_CYCLES  execute occupancy of MUL* ops (1..255).
//   DIV_CYCLES  execute occupancy of DIV/REM ops (1..255).
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   instr, in_valid, in_ready   upstream instruction handshake
//   flush                       drop held bundle, cancel interlock
//   out_valid, out_ready        downstream bundle handshake
//   RegWrite .. four_imm_control, mul_sel, div_sel, illegal
//                               registered control bundle
//   busy                        M-op interlock active
module decode_ctrl_stage #(
    parameter bit ENABLE_M   = 1'b1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        RegWrite,
    output logic        ALUsrc,
    output logic        Branch,
    output logic        Jump,
    output logic        MemWrite,
    output logic [3:0]  ALUctrl,
    output logic [2:0]  ImmSrc,
    output logic [1:0]  destsrc,
    output logic [2:0]  memCtrl,
    output logic        UI_control,
    output logic        RD1_control,
    output logic        PC_RD1_control,
    output logic        four_imm_control,
    output logic        mul_sel,
    output logic        div_sel,
    output logic        illegal,
    output logic        busy
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // The counter reloads with LAT-1 on handoff. That makes the next load
    // possible exactly LAT cycles after the handoff cycle.
    localparam logic [7:0] MUL_RELOAD = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] DIV_RELOAD = 8'(DIV_CYCLES - 1);

    typedef struct packed {
        logic       regWrite;
        logic       aluSrc;
        logic       branch;
        logic       jump;
        logic       memWrite;
        logic [3:0] aluCtrl;
        logic [2:0] immSrc;
        logic [1:0] destSrc;
        logic [2:0] memCtrl;
        logic       uiCtrl;
        logic       rd1Ctrl;
        logic       pcRd1Ctrl;
        logic       fourImmCtrl;
        logic       mulSel;
        logic       divSel;
        logic       illegal;
    } ctrl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;
    ctrl_t      bundle_d;
    ctrl_t      bundle_q;
    logic       outValid_d;
    logic       outValid_q;
    logic [7:0] count_d;
    logic [7:0] count_q;
    logic       mOpHeld;
    logic       load;
    logic       handoff;
    logic       unusedFields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Register indices are consumed by the register-read stage, not here.
    assign unusedFields = ^{instr[24:15], instr[11:7]};

    // Combinational decode of the incoming instruction. Every field starts at
    // its inactive value. The operand-mux flags default to 1 and are cleared
    // only by the opcodes that use the alternate operand. An encoding that is
    // not recognised collapses the whole bundle to zero with only illegal set.
    // The illegal bundle still flows downstream.
    always_comb begin
        bundle_d             = '0;
        bundle_d.memCtrl     = funct3;
        bundle_d.uiCtrl      = 1'b1;
        bundle_d.rd1Ctrl     = 1'b1;
        bundle_d.pcRd1Ctrl   = 1'b1;
        bundle_d.fourImmCtrl = 1'b1;
        legal                = 1'b1;

        case (opcode)
            OP_R: begin
                // An M op is recognised only from the full funct7 pattern.
                // Checking instr[25] alone would also match reserved encodings.
                case (funct7)
                    F7_BASE, F7_ALT: begin
                        bundle_d.regWrite = 1'b1;
                        bundle_d.aluCtrl  = {instr[30], funct3};
                    end
                    F7_MULDIV: begin
                        if (ENABLE_M) begin
                            bundle_d.regWrite = 1'b1;
                            bundle_d.aluCtrl  = {instr[30], funct3};
                            bundle_d.mulSel   = ~funct3[2];
                            bundle_d.divSel   = funct3[2];
                        end else begin
                            legal = 1'b0;
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                // instr[30] picks SRAI over SRLI. For other immediate ops that
                // bit is part of the immediate, so it must not reach the ALU.
                bundle_d.aluCtrl = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
                bundle_d.aluSrc  = 1'b1;
            end
            OP_LOAD: begin
                bundle_d.aluSrc   = 1'b1;
                bundle_d.destSrc  = 2'd1;
                bundle_d.regWrite = 1'b1;
            end
            OP_BRANCH: begin
                bundle_d.branch  = 1'b1;
                bundle_d.immSrc  = 3'd1;
                bundle_d.aluCtrl = {1'b0, funct3};
            end
            OP_STORE: begin
                bundle_d.memWrite = 1'b1;
                bundle_d.aluSrc   = 1'b1;
                bundle_d.immSrc   = 3'd2;
            end
            OP_LUI: begin
                bundle_d.regWrite = 1'b1;
                bundle_d.aluSrc   = 1'b1;
                bundle_d.immSrc   = 3'd3;
                bundle_d.uiCtrl   = 1'b0;
                bundle_d.rd1Ctrl  = 1'b0;
            end
            OP_AUIPC: begin
                bundle_d.regWrite = 1'b1;
                bundle_d.aluSrc   = 1'b1;
                bundle_d.immSrc   = 3'd3;
                bundle_d.rd1Ctrl  = 1'b0;
            end
            OP_JAL: begin
                bundle_d.jump        = 1'b1;
                bundle_d.immSrc      = 3'd4;
                bundle_d.destSrc     = 2'd3;
                bundle_d.regWrite    = 1'b1;
                bundle_d.fourImmCtrl = 1'b0;
                bundle_d.rd1Ctrl     = 1'b0;
            end
            OP_JALR: begin
                bundle_d.jump        = 1'b1;
                bundle_d.destSrc     = 2'd3;
                bundle_d.regWrite    = 1'b1;
                bundle_d.fourImmCtrl = 1'b0;
                bundle_d.rd1Ctrl     = 1'b0;
                bundle_d.pcRd1Ctrl   = 1'b0;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            bundle_d         = '0;
            bundle_d.illegal = 1'b1;
        end
    end

    // Handshake. A held M op must leave before anything new is taken. Its
    // handoff cycle loads the interlock counter, and the counter then keeps
    // the stage closed. Flush also closes the stage for its cycle.
    assign mOpHeld  = bundle_q.mulSel | bundle_q.divSel;
    assign busy     = (count_q != 8'd0);
    assign in_ready = ~flush & ~busy & (~outValid_q | (out_ready & ~mOpHeld));
    assign load     = in_valid & in_ready;
    assign handoff  = outValid_q & out_ready & ~flush;

    // Next state for the valid flag and the interlock counter. Flush wins
    // over everything. It kills the bundle and any running interlock.
    always_comb begin
        outValid_d = outValid_q;
        count_d    = count_q;
        if (flush) begin
            outValid_d = 1'b0;
            count_d    = 8'd0;
        end else begin
            if (load) begin
                outValid_d = 1'b1;
            end else if (handoff) begin
                outValid_d = 1'b0;
            end

            if (handoff && mOpHeld) begin
                count_d = bundle_q.divSel ? DIV_RELOAD : MUL_RELOAD;
            end else if (count_q != 8'd0) begin
                count_d = count_q - 8'd1;
            end
        end
    end

    // State registers. The bundle updates only on load, so it stays stable
    // while downstream stalls. Reset clears everything at once, including a
    // running interlock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q   <= '0;
            outValid_q <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            outValid_q <= outValid_d;
            count_q    <= count_d;
            if (load) begin
                bundle_q <= bundle_d;
            end
        end
    end

    assign out_valid        = outValid_q;
    assign RegWrite         = bundle_q.regWrite;
    assign ALUsrc           = bundle_q.aluSrc;
    assign Branch           = bundle_q.branch;
    assign Jump             = bundle_q.jump;
    assign MemWrite         = bundle_q.memWrite;
    assign ALUctrl          = bundle_q.aluCtrl;
    assign ImmSrc           = bundle_q.immSrc;
    assign destsrc          = bundle_q.destSrc;
    assign memCtrl          = bundle_q.memCtrl;
    assign UI_control       = bundle_q.uiCtrl;
    assign RD1_control      = bundle_q.rd1Ctrl;
    assign PC_RD1_control   = bundle_q.pcRd1Ctrl;
    assign four_imm_control = bundle_q.fourImmCtrl;
    assign mul_sel          = bundle_q.mulSel;
    assign div_sel          = bundle_q.divSel;
    assign illegal          = bundle_q.illegal;

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
- Registered RV32I(+M) decode stage: decodes the instruction into the pipeline control bundle and holds it in an output register with a valid/ready handshake, synchronous flush, and a multi-cycle M-extension issue interlock.
- Sits between fetch and the register-read/execute stage.
- Fixes R-type mul detection: requires funct7 = 0000001, not instr[25] alone.

Parameters:
- ENABLE_M, 1: 1 = decode MUL/DIV group; 0 = funct7 0000001 R-types flagged illegal.
- MUL_CYCLES, 2: execute occupancy of MUL* ops, 1..255.
- DIV_CYCLES, 33: execute occupancy of DIV/REM ops, 1..255.

Ports:
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- instr in 32: fetched instruction.
- in_valid in 1: instr valid.
- in_ready out 1: stage can accept instr this cycle.
- flush in 1: discard held bundle and cancel interlock.
- out_valid out 1: bundle valid.
- out_ready in 1: downstream accepts bundle.
- RegWrite, ALUsrc, Branch, Jump, MemWrite out 1 each: control flags.
- ALUctrl out 4: ALU operation.
- ImmSrc out 3: immediate format.
- destsrc out 2: writeback source.
- memCtrl out 3: instr[14:12].
- UI_control, RD1_control, PC_RD1_control, four_imm_control out 1 each: operand muxes.
- mul_sel, div_sel out 1 each: M-extension multiply or divide.
- illegal out 1: unrecognised encoding.
- busy out 1: M-op interlock active.

Behaviour:
- Reset (async, rst_n=0): every registered output is 0, out_valid=0, busy=0, counter=0. in_ready=1 after reset.
- Decode is combinational on instr and captured on load (in_valid & in_ready). Latency is 1 cycle.
- Opcode map:
  - 0110011 R: RegWrite=1, ALUctrl={instr[30],f3}, ALUsrc=0, ImmSrc=0.
  - 0010011 I: ALUctrl={f3==101 ? instr[30] : 0, f3}, ALUsrc=1, ImmSrc=0.
  - 0000011 load: ALUsrc=1, destsrc=1, RegWrite=1.
  - 1100011 branch: Branch=1, ImmSrc=1, ALUctrl={0,f3}.
  - 0100011 store: MemWrite=1, ALUsrc=1, ImmSrc=2.
  - 0110111 LUI and 0010111 AUIPC: RegWrite=1, ALUsrc=1, ImmSrc=3.
  - 1101111 JAL: Jump=1, ImmSrc=4, destsrc=3, RegWrite=1.
  - 1100111 JALR: Jump=1, ImmSrc=0, destsrc=3, RegWrite=1.
  - Unlisted fields are 0.
- Operand-mux flags:
  - four_imm_control=0 for JAL/JALR.
  - UI_control=0 for LUI.
  - RD1_control=0 for LUI/AUIPC/JAL/JALR.
  - PC_RD1_control=0 for JALR.
  - All of the above are 1 otherwise.
- M group: opcode 0110011, funct7=0000001, ENABLE_M=1. mul_sel=1 when f3[2]=0; div_sel=1 when f3[2]=1.
- Illegal encodings:
  - R-type with funct7 not in {0000000, 0100000, 0000001(if ENABLE_M)}.
  - Any unlisted opcode.
  - Result: all control fields 0, illegal=1, bundle still passes with out_valid=1.
- Handshake:
  - in_ready = ~busy & (~out_valid | (out_ready & ~(mul_sel|div_sel))).
  - out_valid set on load. It clears on handoff (out_valid & out_ready) when no load occurs in the same cycle.
  - Bundle fields stay stable while out_valid & ~out_ready.
- Interlock: on handoff of an M-op, the counter loads LAT-1 (LAT = MUL_CYCLES or DIV_CYCLES).
  - busy = (counter != 0); the counter decrements each cycle while nonzero.
  - The next load is possible exactly LAT cycles after the handoff cycle.
  - LAT=1 gives no busy cycles.
- Flush (synchronous, highest priority): out_valid<=0, counter<=0.
  - Any load or handoff in that cycle is suppressed; in_ready=0 while flush=1.
  - Fields may hold stale values but out_valid=0.
- Reset mid-interlock clears the counter immediately.

Test Plan:
- Reset, then `add x1,x2,x3` (0x003100B3) with in_valid=1 and out_ready=1 → next cycle: out_valid=1, RegWrite=1, ALUctrl=0000, mul_sel=0; in_ready stays 1.
- `srai` (0x4020D093) → ALUctrl=1101, ALUsrc=1. `sub` with funct7=0100000 → ALUctrl=1000. R-type with funct7=0000010 → illegal=1, RegWrite=0.
- DIV_CYCLES=4, `div` (0x0220C0B3) handed off at cycle t → in_ready=0 at t; busy=1 at t+1..t+3; in_ready=1 at t+4; div_sel=1, mul_sel=0.
- Hold out_ready=0 for 3 cycles with a JAL held → out_valid stays 1, fields stable (Jump=1, destsrc=3, ImmSrc=4, four_imm_control=0), in_ready=0. Raise out_ready → handoff and new load in the same cycle.
- Assert flush during `mul` interlock (busy=1, counter=1) → busy=0 and out_valid=0 next cycle; load accepted the following cycle.
- ENABLE_M=0 with `mul` → illegal=1, mul_sel=0, busy never asserts.
